// File: rtl/iteration_pixel_writer_pkg.sv
// Shared types and constants for the iteration pixel writer: FSM encoding,
// colour and pixel-address widths, and the palette generator used by the ROM.
package iteration_pixel_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_FRAME   = 3'd4
    } state_e;

    localparam int unsigned       RGB_W        = 24;
    localparam int unsigned       PIX_AW       = 21;
    localparam logic [RGB_W-1:0]  COLOUR_BLACK = '0;
    localparam logic [RGB_W-1:0]  SAT_MAX      = '1;

    // Fixed palette: bands hue bits so neighbouring iteration counts stay distinguishable.
    function automatic logic [RGB_W-1:0] palette_entry(input logic [7:0] idx);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = {idx[3:0], idx[7:4]};
        g = ~idx;
        b = idx ^ 8'h5A;
        return {r, g, b};
    endfunction

endpackage

// File: rtl/iteration_pixel_writer_palette_rom.sv
// 256-entry registered palette ROM (one cycle read latency); only built when
// MANDEL_PALETTE_LUT_EN is defined.
`ifdef MANDEL_PALETTE_LUT_EN
module mandel_palette_rom
    import iteration_pixel_writer_pkg::*;
(
    input  logic             clk,
    input  logic [7:0]       addr_i,
    output logic [RGB_W-1:0] rgb_o
);

    logic [RGB_W-1:0] rgb_q;

    always_ff @(posedge clk) begin
        rgb_q <= palette_entry(addr_i);
    end

    assign rgb_o = rgb_q;

endmodule
`endif

// File: rtl/iteration_pixel_writer.sv
// Pulls SET_SIZE iteration words per engine handshake and writes them as RGB888 pixels.
// MANDEL_PALETTE_LUT_EN selects the registered palette ROM instead of greyscale.
module iteration_pixel_writer
    import iteration_pixel_writer_pkg::*;
#(
    parameter int unsigned HBI      = 32,
    parameter int unsigned SET_SIZE = 1,
    parameter int unsigned MAX_ITER = 255
) (
    input  logic              CLK,
    input  logic              SYS_RESET_N,
    input  logic              render_reset,
    input  logic [PIX_AW-1:0] total_pixels,
    input  logic              eng_ready,
    input  logic [HBI-1:0]    eng_data,
    input  logic              eng_frame_ready,
    output logic              send_data,
    output logic              clear_frame,
    output logic [PIX_AW-1:0] mem_addr,
    output logic [RGB_W-1:0]  mem_wdata,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              frame_done,
    output logic [PIX_AW-1:0] pixel_count
);

    localparam int unsigned      IDX_W    = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SET_SIZE - 1);
    localparam int unsigned      EXT_W    = (HBI > RGB_W) ? HBI : RGB_W;

    function automatic logic [RGB_W-1:0] saturate(input logic [HBI-1:0] it);
        logic [EXT_W-1:0] ext;
        ext = EXT_W'(it);
        return (ext > EXT_W'(SAT_MAX)) ? SAT_MAX : ext[RGB_W-1:0];
    endfunction

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [PIX_AW-1:0] pix_q, pix_d, pix_inc;
    logic [HBI-1:0]    buf_q [SET_SIZE];
    logic [HBI-1:0]    buf_d [SET_SIZE];
    logic              frame_pulse_q, frame_pulse_d;

    logic [RGB_W-1:0]  sat_cur;
    logic [RGB_W-1:0]  base_colour;
    logic [RGB_W-1:0]  colour;
    logic              in_set;
    logic              colour_ready;

    assign pix_inc = pix_q + PIX_AW'(1);
    assign sat_cur = saturate(buf_q[idx_q]);
    assign in_set  = 32'(sat_cur) >= 32'(MAX_ITER);

`ifdef MANDEL_PALETTE_LUT_EN
    logic [RGB_W-1:0] rom_sat;
    logic [7:0]       rom_addr;
    logic [RGB_W-1:0] lut_rgb;
    logic             lut_ok_q;

    // ROM is addressed with the next entry so only the first entry of a set pays the read latency.
    assign rom_sat  = saturate(buf_q[idx_d]);
    assign rom_addr = rom_sat[7:0];

    mandel_palette_rom u_palette_rom (
        .clk    (CLK),
        .addr_i (rom_addr),
        .rgb_o  (lut_rgb)
    );

    always_ff @(posedge CLK or negedge SYS_RESET_N) begin
        if (!SYS_RESET_N) begin
            lut_ok_q <= 1'b0;
        end else begin
            lut_ok_q <= (state_q == ST_WRITE) && (state_d == ST_WRITE);
        end
    end

    assign base_colour  = lut_rgb;
    assign colour_ready = lut_ok_q;
`else
    assign base_colour  = {3{sat_cur[7:0]}};
    assign colour_ready = 1'b1;
`endif

    assign colour = in_set ? COLOUR_BLACK : base_colour;

    always_ff @(posedge CLK or negedge SYS_RESET_N) begin
        if (!SYS_RESET_N) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            pix_q         <= '0;
            buf_q         <= '{default: '0};
            frame_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pix_q         <= pix_d;
            buf_q         <= buf_d;
            frame_pulse_q <= frame_pulse_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        pix_d         = pix_q;
        buf_d         = buf_q;
        frame_pulse_d = 1'b0;
        send_data     = 1'b0;
        mem_we        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (eng_ready) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                send_data = 1'b1;
                idx_d     = '0;
                state_d   = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                buf_d[idx_q] = eng_data;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_WRITE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_WRITE: begin
                // Entries past the frame end are dropped by leaving the set early.
                if (pix_q >= total_pixels) begin
                    idx_d   = '0;
                    state_d = ST_FRAME;
                end else if (colour_ready) begin
                    mem_we = 1'b1;
                    if (mem_ack) begin
                        pix_d = pix_inc;
                        if ((idx_q == LAST_IDX) || (pix_inc >= total_pixels)) begin
                            idx_d   = '0;
                            state_d = (pix_inc >= total_pixels) ? ST_FRAME : ST_IDLE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            ST_FRAME: begin
                if (eng_frame_ready) begin
                    frame_pulse_d = 1'b1;
                    pix_d         = '0;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (render_reset) begin
            state_d       = ST_IDLE;
            idx_d         = '0;
            pix_d         = '0;
            buf_d         = '{default: '0};
            frame_pulse_d = 1'b0;
        end
    end

    assign mem_addr    = mem_we ? pix_q : '0;
    assign mem_wdata   = mem_we ? colour : '0;
    assign clear_frame = frame_pulse_q;
    assign frame_done  = frame_pulse_q;
    assign pixel_count = pix_q;

endmodule

// File: tb/tb_iteration_pixel_writer.sv
// Directed bench for iteration_pixel_writer: instance A (SET_SIZE=1, 4-pixel frame)
// and instance B (SET_SIZE=4, 6-pixel frame), scoreboarded memory writes.
module tb_iteration_pixel_writer;

    typedef struct packed {
        logic [20:0] addr;
        logic [23:0] data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;

    logic        render_reset_a = 1'b0;
    logic [20:0] total_pixels_a = 21'd4;
    logic        eng_ready_a = 1'b0;
    logic [31:0] eng_data_a = '0;
    logic        eng_frame_ready_a = 1'b0;
    logic        send_data_a, clear_frame_a, mem_we_a, frame_done_a, mem_ack_a;
    logic [20:0] mem_addr_a, pixel_count_a;
    logic [23:0] mem_wdata_a;
    logic        ack_resp_a = 1'b0;
    logic        ack_man_a = 1'b0;
    logic        man_mode_a = 1'b0;

    logic        render_reset_b = 1'b0;
    logic [20:0] total_pixels_b = 21'd6;
    logic        eng_ready_b = 1'b0;
    logic [31:0] eng_data_b = '0;
    logic        eng_frame_ready_b = 1'b0;
    logic        send_data_b, clear_frame_b, mem_we_b, frame_done_b, mem_ack_b;
    logic [20:0] mem_addr_b, pixel_count_b;
    logic [23:0] mem_wdata_b;
    logic        ack_resp_b = 1'b0;

    assign mem_ack_a = ack_resp_a | ack_man_a;
    assign mem_ack_b = ack_resp_b;

    iteration_pixel_writer #(.HBI(32), .SET_SIZE(1), .MAX_ITER(255)) dut_a (
        .CLK(clk), .SYS_RESET_N(rst_n), .render_reset(render_reset_a),
        .total_pixels(total_pixels_a), .eng_ready(eng_ready_a), .eng_data(eng_data_a),
        .eng_frame_ready(eng_frame_ready_a), .send_data(send_data_a),
        .clear_frame(clear_frame_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_we(mem_we_a), .mem_ack(mem_ack_a), .frame_done(frame_done_a),
        .pixel_count(pixel_count_a)
    );

    iteration_pixel_writer #(.HBI(32), .SET_SIZE(4), .MAX_ITER(255)) dut_b (
        .CLK(clk), .SYS_RESET_N(rst_n), .render_reset(render_reset_b),
        .total_pixels(total_pixels_b), .eng_ready(eng_ready_b), .eng_data(eng_data_b),
        .eng_frame_ready(eng_frame_ready_b), .send_data(send_data_b),
        .clear_frame(clear_frame_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_we(mem_we_b), .mem_ack(mem_ack_b), .frame_done(frame_done_b),
        .pixel_count(pixel_count_b)
    );

    int unsigned total = 0;
    int unsigned bad = 0;
    wr_t exp_a[$];
    wr_t exp_b[$];
    int  next_a = 0;
    int  next_b = 0;
    int  held_a = 0;
    int  held_b = 0;
    int  wr_cnt_b = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_col(input logic [31:0] it);
        return (it >= 32'd255) ? 24'h000000 : {it[7:0], it[7:0], it[7:0]};
    endfunction

    // Memory responder A: checks every held cycle against the scoreboard, acks on the 3rd.
    always @(negedge clk) begin
        if (ack_resp_a) begin
            ack_resp_a = 1'b0;
            held_a     = 0;
        end else if (rst_n === 1'b1 && mem_we_a === 1'b1) begin
            held_a++;
            total++;
            assert (exp_a.size() != 0) else begin
                bad++;
                $error("FAIL a_unexpected_write: observed addr=%0h expected=no write", mem_addr_a);
            end
            if (exp_a.size() != 0) begin
                check("a_addr", 32'(mem_addr_a), 32'(exp_a[0].addr));
                check("a_wdata", 32'(mem_wdata_a), 32'(exp_a[0].data));
            end
            if (!man_mode_a && held_a == 3) begin
                ack_resp_a = 1'b1;
                if (exp_a.size() != 0) void'(exp_a.pop_front());
            end
        end else begin
            held_a = 0;
        end
    end

    // Memory responder B: acks on the first held cycle.
    always @(negedge clk) begin
        if (ack_resp_b) begin
            ack_resp_b = 1'b0;
            held_b     = 0;
        end else if (rst_n === 1'b1 && mem_we_b === 1'b1) begin
            held_b++;
            total++;
            assert (exp_b.size() != 0) else begin
                bad++;
                $error("FAIL b_unexpected_write: observed addr=%0h expected=no write", mem_addr_b);
            end
            if (exp_b.size() != 0) begin
                check("b_addr", 32'(mem_addr_b), 32'(exp_b[0].addr));
                check("b_wdata", 32'(mem_wdata_b), 32'(exp_b[0].data));
            end
            if (held_b == 1) begin
                ack_resp_b = 1'b1;
                wr_cnt_b++;
                if (exp_b.size() != 0) void'(exp_b.pop_front());
            end
        end else begin
            held_b = 0;
        end
    end

    task automatic hs_a(input logic [31:0] d);
        exp_a.push_back({21'(next_a), exp_col(d)});
        next_a++;
        eng_ready_a = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (send_data_a) break;
        end
        check("a_send_data", 32'(send_data_a), 32'd1);
        eng_ready_a = 1'b0;
        eng_data_a  = d;
        @(negedge clk);
        check("a_send_pulse_len", 32'(send_data_a), 32'd0);
    endtask

    task automatic hs_b(input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3);
        logic [31:0] d [4];
        d = '{d0, d1, d2, d3};
        for (int k = 0; k < 4; k++) begin
            if (next_b < 6) exp_b.push_back({21'(next_b), exp_col(d[k])});
            next_b++;
        end
        eng_ready_b = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (send_data_b) break;
        end
        check("b_send_data", 32'(send_data_b), 32'd1);
        eng_ready_b = 1'b0;
        eng_data_b  = d[0];
        @(negedge clk);
        check("b_send_pulse_len", 32'(send_data_b), 32'd0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            eng_data_b = d[k];
        end
    endtask

    task automatic wait_pix_a(input int target, input string tag);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (pixel_count_a == 21'(target)) break;
        end
        check(tag, 32'(pixel_count_a), 32'(target));
    endtask

    task automatic wait_we_a(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_we_a) break;
        end
        check(tag, 32'(mem_we_a), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_send_data", 32'(send_data_a), 32'd0);
        check("rst_clear_frame", 32'(clear_frame_a), 32'd0);
        check("rst_mem_we", 32'(mem_we_a), 32'd0);
        check("rst_mem_addr", 32'(mem_addr_a), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata_a), 32'd0);
        check("rst_frame_done", 32'(frame_done_a), 32'd0);
        check("rst_pixel_count", 32'(pixel_count_a), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_mem_we_b", 32'(mem_we_b), 32'd0);

        // Ack with no write in flight must be ignored.
        ack_man_a = 1'b1;
        @(negedge clk);
        ack_man_a = 1'b0;
        @(negedge clk);
        check("stray_ack_pix", 32'(pixel_count_a), 32'd0);

        // Instance B: two sets of four into a 6-pixel frame, last two entries dropped.
        hs_b(32'd1, 32'd2, 32'd3, 32'd4);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (pixel_count_b == 21'd4) break;
        end
        check("b_pix_after_set1", 32'(pixel_count_b), 32'd4);
        hs_b(32'd5, 32'd6, 32'd7, 32'd8);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (pixel_count_b == 21'd6) break;
        end
        check("b_pix_after_set2", 32'(pixel_count_b), 32'd6);
        repeat (4) @(negedge clk);
        check("b_write_count", 32'(wr_cnt_b), 32'd6);
        check("b_pending", 32'(exp_b.size()), 32'd0);
        check("b_pix_hold_frame", 32'(pixel_count_b), 32'd6);
        eng_frame_ready_b = 1'b1;
        @(negedge clk);
        eng_frame_ready_b = 1'b0;
        check("b_frame_done", 32'(frame_done_b), 32'd1);
        check("b_frame_pix", 32'(pixel_count_b), 32'd0);

        // Instance A: greyscale, in-set and saturated words, then frame end.
        hs_a(32'h0000_002A);
        wait_pix_a(1, "a_pix_after_2a");
        hs_a(32'd255);
        wait_pix_a(2, "a_pix_after_255");
        hs_a(32'hFFFF_FFFF);
        wait_pix_a(3, "a_pix_after_max");
        hs_a(32'h0000_0080);
        wait_pix_a(4, "a_pix_after_80");
        eng_ready_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("a_no_early_frame_done", 32'(frame_done_a), 32'd0);
            check("a_ready_ignored_in_frame", 32'(send_data_a), 32'd0);
        end
        eng_ready_a       = 1'b0;
        eng_frame_ready_a = 1'b1;
        @(negedge clk);
        eng_frame_ready_a = 1'b0;
        check("a_frame_done", 32'(frame_done_a), 32'd1);
        check("a_clear_frame", 32'(clear_frame_a), 32'd1);
        check("a_frame_pix", 32'(pixel_count_a), 32'd0);
        @(negedge clk);
        check("a_frame_done_one_cycle", 32'(frame_done_a), 32'd0);
        check("a_clear_frame_one_cycle", 32'(clear_frame_a), 32'd0);
        next_a = 0;

        // render_reset coinciding with the ack of pixel 3.
        hs_a(32'd1);
        wait_pix_a(1, "a_rr_pix1");
        hs_a(32'd2);
        wait_pix_a(2, "a_rr_pix2");
        hs_a(32'd3);
        wait_pix_a(3, "a_rr_pix3");
        man_mode_a = 1'b1;
        hs_a(32'd4);
        wait_we_a("a_rr_we_seen");
        @(negedge clk);
        ack_man_a      = 1'b1;
        render_reset_a = 1'b1;
        @(negedge clk);
        ack_man_a      = 1'b0;
        render_reset_a = 1'b0;
        check("a_rr_mem_we", 32'(mem_we_a), 32'd0);
        check("a_rr_pix", 32'(pixel_count_a), 32'd0);
        void'(exp_a.pop_front());
        next_a     = 0;
        man_mode_a = 1'b0;

        // Asynchronous reset in the middle of a write.
        hs_a(32'h11);
        wait_pix_a(1, "a_sr_pix1");
        man_mode_a = 1'b1;
        hs_a(32'h22);
        wait_we_a("a_sr_we_seen");
        #2 rst_n = 1'b0;
        #1;
        check("a_sr_mem_we", 32'(mem_we_a), 32'd0);
        check("a_sr_pix", 32'(pixel_count_a), 32'd0);
        check("a_sr_mem_addr", 32'(mem_addr_a), 32'd0);
        check("a_sr_mem_wdata", 32'(mem_wdata_a), 32'd0);
        void'(exp_a.pop_front());
        next_a     = 0;
        man_mode_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        hs_a(32'h33);
        wait_pix_a(1, "a_after_reset_pix");

        repeat (4) @(negedge clk);
        check("a_pending", 32'(exp_a.size()), 32'd0);
        check("b_pending_end", 32'(exp_b.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
